matrix_wb_arbiter: RTL and testbench

Two-master round-robin arbiter for the pipelined Wishbone slave port of the 8x8 LED matrix driver. It sits between the matrix framebuffer port and two requesters: the ESP32-side bus bridge (master 0) and the on-FPGA pattern generator (master 1). Both can then write and read the framebuffer without colliding. A grant is held for the whole Wishbone cycle (CYC high), and acks are routed back only to the owning master.

---
 rtl/matrix_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_matrix_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_wb_arbiter.sv
// matrix_wb_arbiter
// Two-master round-robin arbiter in front of the LED matrix framebuffer's
// pipelined Wishbone slave port. Master 0 is the ESP32 bus bridge, master 1
// the on-FPGA pattern generator. A grant is held for the whole CYC, and acks
// are routed only to the owning master.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   i_m{0,1}_cyc/stb/we    master bus controls
//   i_m{0,1}_addr/sel/wdata master request payload
//   o_m{0,1}_ack/stall     per-master ack / stall
//   o_m{0,1}_rdata         read data (shared from the slave)
//   o_s_cyc/stb/we/addr/sel/wdata  muxed request toward the slave
//   i_s_ack/stall/rdata    slave responses
//   o_grant                one-hot owner, 00 when idle
//   o_outstanding          accepted but not yet acked requests
module matrix_wb_arbiter #(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                            clk,
    input  logic                            resetn,

    input  logic                            i_m0_cyc,
    input  logic                            i_m0_stb,
    input  logic                            i_m0_we,
    input  logic [AW-1:0]                   i_m0_addr,
    input  logic [DW/8-1:0]                 i_m0_sel,
    input  logic [DW-1:0]                   i_m0_wdata,
    output logic                            o_m0_ack,
    output logic                            o_m0_stall,
    output logic [DW-1:0]                   o_m0_rdata,

    input  logic                            i_m1_cyc,
    input  logic                            i_m1_stb,
    input  logic                            i_m1_we,
    input  logic [AW-1:0]                   i_m1_addr,
    input  logic [DW/8-1:0]                 i_m1_sel,
    input  logic [DW-1:0]                   i_m1_wdata,
    output logic                            o_m1_ack,
    output logic                            o_m1_stall,
    output logic [DW-1:0]                   o_m1_rdata,

    output logic                            o_s_cyc,
    output logic                            o_s_stb,
    output logic                            o_s_we,
    output logic [AW-1:0]                   o_s_addr,
    output logic [DW/8-1:0]                 o_s_sel,
    output logic [DW-1:0]                   o_s_wdata,
    input  logic                            i_s_ack,
    input  logic                            i_s_stall,
    input  logic [DW-1:0]                   i_s_rdata,

    output logic [1:0]                      o_grant,
    output logic [$clog2(MAX_OUT+1)-1:0]    o_outstanding
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            g0, g1;
    logic            cnt_full;
    logic            accept;
    logic            ack_routed;

    assign g0       = (state_q == ST_G0);
    assign g1       = (state_q == ST_G1);
    assign cnt_full = (cnt_q == CW'(MAX_OUT));

    // Request mux toward the slave; stb is held off once the outstanding limit is hit.
    always_comb begin
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_s_we    = 1'b0;
        o_s_addr  = '0;
        o_s_sel   = '0;
        o_s_wdata = '0;
        if (g0) begin
            o_s_cyc   = i_m0_cyc;
            o_s_stb   = i_m0_stb & ~cnt_full;
            o_s_we    = i_m0_we;
            o_s_addr  = i_m0_addr;
            o_s_sel   = i_m0_sel;
            o_s_wdata = i_m0_wdata;
        end else if (g1) begin
            o_s_cyc   = i_m1_cyc;
            o_s_stb   = i_m1_stb & ~cnt_full;
            o_s_we    = i_m1_we;
            o_s_addr  = i_m1_addr;
            o_s_sel   = i_m1_sel;
            o_s_wdata = i_m1_wdata;
        end
    end

    // A zero count discards stray acks, e.g. late acks after an aborted cycle.
    assign ack_routed = i_s_ack & (g0 | g1) & (cnt_q != '0);
    assign accept     = o_s_stb & ~i_s_stall;

    assign o_m0_ack   = ack_routed & g0;
    assign o_m1_ack   = ack_routed & g1;
    assign o_m0_stall = g0 ? (cnt_full | i_s_stall) : 1'b1;
    assign o_m1_stall = g1 ? (cnt_full | i_s_stall) : 1'b1;
    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;

    assign o_grant       = {g1, g0};
    assign o_outstanding = cnt_q;

    // Arbitration: ties go to the master that was not granted last; no preemption.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (i_m0_cyc) begin
                    state_d = ST_G0;
                end else if (i_m1_cyc) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                if (!i_m0_cyc) begin
                    state_d = i_m1_cyc ? ST_G1 : ST_IDLE;
                end
            end
            ST_G1: begin
                if (!i_m1_cyc) begin
                    state_d = i_m0_cyc ? ST_G0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_G0) begin
            last_d = 1'b0;
        end else if (state_d == ST_G1) begin
            last_d = 1'b1;
        end

        // Any change of owner (including release to idle) abandons outstanding acks.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (accept && !ack_routed) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && ack_routed) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    logic unused_sw;
    assign unused_sw = (SW == 0);

endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// Bench for matrix_wb_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural owner/count model.
module tb_matrix_wb_arbiter;

    localparam int unsigned AW      = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned MAX_OUT = 4;

    logic        clk;
    logic        resetn;
    logic        i_m0_cyc, i_m0_stb, i_m0_we;
    logic [3:0]  i_m0_addr, i_m0_sel;
    logic [31:0] i_m0_wdata;
    logic        o_m0_ack, o_m0_stall;
    logic [31:0] o_m0_rdata;
    logic        i_m1_cyc, i_m1_stb, i_m1_we;
    logic [3:0]  i_m1_addr, i_m1_sel;
    logic [31:0] i_m1_wdata;
    logic        o_m1_ack, o_m1_stall;
    logic [31:0] o_m1_rdata;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [3:0]  o_s_addr, o_s_sel;
    logic [31:0] o_s_wdata;
    logic        i_s_ack, i_s_stall;
    logic [31:0] i_s_rdata;
    logic [1:0]  o_grant;
    logic [2:0]  o_outstanding;

    int total = 0;
    int bad   = 0;

    // Reference model: owner (-1 idle, 0, 1), last granted master, outstanding count.
    int m_owner;
    int m_last;
    int m_cnt;

    matrix_wb_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_addr(i_m0_addr), .i_m0_sel(i_m0_sel), .i_m0_wdata(i_m0_wdata),
        .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_rdata(o_m0_rdata),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_addr(i_m1_addr), .i_m1_sel(i_m1_sel), .i_m1_wdata(i_m1_wdata),
        .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_rdata(o_m1_rdata),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_sel(o_s_sel), .o_s_wdata(o_s_wdata),
        .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_rdata(i_s_rdata),
        .o_grant(o_grant), .o_outstanding(o_outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
    endtask

    task automatic idle_inputs();
        i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = 0; i_m0_sel = 0; i_m0_wdata = 0;
        i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = 0; i_m1_sel = 0; i_m1_wdata = 0;
        i_s_ack = 0; i_s_stall = 0; i_s_rdata = 0;
    endtask

    // Check all outputs for the current inputs, then advance one clock with the model.
    task automatic cycle();
        logic        cy[2], sb[2], we[2];
        logic [3:0]  ad[2], se[2];
        logic [31:0] wd[2];
        logic        e_cyc, e_stb, e_we;
        logic [3:0]  e_addr, e_sel;
        logic [31:0] e_wdata;
        logic        e_stall[2], e_ack[2];
        logic [1:0]  e_grant;
        int          nxt, acc, ackd;
        bit          full;

        #1;
        cy[0] = i_m0_cyc; sb[0] = i_m0_stb; we[0] = i_m0_we;
        ad[0] = i_m0_addr; se[0] = i_m0_sel; wd[0] = i_m0_wdata;
        cy[1] = i_m1_cyc; sb[1] = i_m1_stb; we[1] = i_m1_we;
        ad[1] = i_m1_addr; se[1] = i_m1_sel; wd[1] = i_m1_wdata;

        full    = (m_cnt == MAX_OUT);
        e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_sel = 0; e_wdata = 0;
        if (m_owner >= 0) begin
            e_cyc   = cy[m_owner];
            e_stb   = sb[m_owner] && !full;
            e_we    = we[m_owner];
            e_addr  = ad[m_owner];
            e_sel   = se[m_owner];
            e_wdata = wd[m_owner];
        end
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = (m_owner == k) ? (full || i_s_stall) : 1'b1;
            e_ack[k]   = (m_owner == k) && i_s_ack && (m_cnt > 0);
        end

        chk("grant", 32'(o_grant), 32'(e_grant));
        chk("s_cyc", 32'(o_s_cyc), 32'(e_cyc));
        chk("s_stb", 32'(o_s_stb), 32'(e_stb));
        chk("s_req", {o_s_we, 7'd0, o_s_addr, o_s_sel, 16'd0}, {e_we, 7'd0, e_addr, e_sel, 16'd0});
        chk("s_wdata", o_s_wdata, e_wdata);
        chk("m0_stall", 32'(o_m0_stall), 32'(e_stall[0]));
        chk("m1_stall", 32'(o_m1_stall), 32'(e_stall[1]));
        chk("m0_ack", 32'(o_m0_ack), 32'(e_ack[0]));
        chk("m1_ack", 32'(o_m1_ack), 32'(e_ack[1]));
        chk("outstanding", 32'(o_outstanding), 32'(m_cnt));
        chk("rdata", {o_m0_rdata ^ i_s_rdata} | {o_m1_rdata ^ i_s_rdata}, 32'd0);

        // Arbitration decision for the next cycle.
        if (m_owner < 0) begin
            if (cy[0] && cy[1]) nxt = 1 - m_last;
            else if (cy[0])     nxt = 0;
            else if (cy[1])     nxt = 1;
            else                nxt = -1;
        end else if (cy[m_owner]) begin
            nxt = m_owner;
        end else begin
            nxt = cy[1 - m_owner] ? 1 - m_owner : -1;
        end
        acc  = (e_stb && !i_s_stall) ? 1 : 0;
        ackd = (e_ack[0] || e_ack[1]) ? 1 : 0;

        @(posedge clk);
        #1;
        if (nxt != m_owner) begin
            m_cnt = 0;
            if (nxt >= 0) m_last = nxt;
        end else begin
            m_cnt = m_cnt + acc - ackd;
        end
        m_owner = nxt;
    endtask

    task automatic rand_inputs(input int p_tog, input int p_stall, input int p_ack);
        if ($urandom_range(99) < p_tog) i_m0_cyc = ~i_m0_cyc;
        if ($urandom_range(99) < p_tog) i_m1_cyc = ~i_m1_cyc;
        i_m0_stb   = i_m0_cyc & ($urandom_range(99) < 70);
        i_m1_stb   = i_m1_cyc & ($urandom_range(99) < 70);
        i_m0_we    = 1'($urandom);
        i_m1_we    = 1'($urandom);
        i_m0_addr  = 4'($urandom);
        i_m1_addr  = 4'($urandom);
        i_m0_sel   = 4'($urandom);
        i_m1_sel   = 4'($urandom);
        i_m0_wdata = $urandom;
        i_m1_wdata = $urandom;
        i_s_stall  = ($urandom_range(99) < p_stall);
        i_s_ack    = ($urandom_range(99) < p_ack);
        i_s_rdata  = $urandom;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        i_s_ack = 1'b1;
        i_m0_cyc = 1'b1;
        #12;
        // Held in reset: idle outputs regardless of requests and slave acks.
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("rst_s_stb", 32'(o_s_stb), 32'd0);
        chk("rst_acks", {30'd0, o_m0_ack, o_m1_ack}, 32'd0);
        chk("rst_stalls", {30'd0, o_m0_stall, o_m1_stall}, 32'd3);
        chk("rst_outstanding", 32'(o_outstanding), 32'd0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Single master: three pipelined writes, slave acks one cycle later.
        i_m0_cyc = 1; cycle();
        for (int i = 0; i < 4; i++) begin
            i_m0_stb = (i < 3); i_m0_we = 1; i_m0_addr = 4'(i); i_m0_sel = 4'hf;
            i_m0_wdata = 32'hA0 + 32'(i);
            i_s_ack = (i > 0);
            cycle();
        end
        idle_inputs(); cycle();

        // Tie, handover without idle, then the next tie alternates.
        i_m0_cyc = 1; i_m1_cyc = 1; cycle(); cycle();
        i_m0_cyc = 0; cycle(); cycle();
        i_m1_cyc = 0; cycle();
        i_m0_cyc = 1; i_m1_cyc = 1; cycle(); cycle();
        idle_inputs(); cycle();

        // Back-pressure in G1.
        i_m1_cyc = 1; cycle();
        i_m1_stb = 1; i_s_stall = 1;
        for (int i = 0; i < 4; i++) cycle();
        idle_inputs(); cycle();

        // Outstanding limit, then abort with acks pending and a late ack.
        i_m0_cyc = 1; cycle();
        i_m0_stb = 1;
        for (int i = 0; i < 6; i++) cycle();
        i_s_ack = 1; cycle();
        i_s_ack = 0; i_m0_stb = 0; cycle();
        i_m0_cyc = 0; cycle();
        i_s_ack = 1; cycle(); cycle();
        idle_inputs(); cycle();

        // Async reset while G1 owns the bus.
        i_m1_cyc = 1; i_m1_stb = 1; cycle(); cycle();
        i_s_ack = 1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_grant", 32'(o_grant), 32'd0);
        chk("arst_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("arst_acks", {30'd0, o_m0_ack, o_m1_ack}, 32'd0);
        chk("arst_stalls", {30'd0, o_m0_stall, o_m1_stall}, 32'd3);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        i_m0_cyc = 1; i_m1_cyc = 1; cycle(); cycle();
        idle_inputs(); cycle();

        // Randomized traffic under several slave behaviours.
        for (int i = 0; i < 600; i++) begin rand_inputs(15, 0, 50); cycle(); end
        for (int i = 0; i < 600; i++) begin rand_inputs(10, 50, 30); cycle(); end
        for (int i = 0; i < 600; i++) begin rand_inputs(5, 10, 5); cycle(); end
        for (int i = 0; i < 600; i++) begin rand_inputs(40, 30, 60); cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
